// File: rtl/br_pkg.sv
// Shared types for the branch resolver: prediction records, the training bundle
// and the RV control-flow opcodes.
package br_pkg;

   localparam int BR_XLEN = 32;

   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_JAL    = 5'b11011;
   localparam logic [4:0] OP_JALR   = 5'b11001;

   typedef struct packed {
      logic [BR_XLEN-1:0] pc;
      logic [BR_XLEN-1:0] target;
      logic               taken;
   } pred_entry_t;

   typedef struct packed {
      logic               valid;
      logic [BR_XLEN-1:0] pc;
      logic [BR_XLEN-1:0] target;
      logic               taken;
      logic               is_br;
      logic               mispredict;
   } upd_t;

endpackage

// File: rtl/br_pred_fifo.sv
// In-order queue of prediction records. Pointers carry one extra wrap bit so that
// full and empty are told apart; clear empties the queue and wins over push/pop.
module br_pred_fifo
   import br_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push_i,
   input  logic        pop_i,
   input  logic        clear_i,
   input  pred_entry_t wdata_i,
   output pred_entry_t rdata_o,
   output logic        empty_o,
   output logic        full_o
);

   localparam int         AW  = $clog2(DEPTH);
   localparam logic [AW:0] ONE = (AW + 1)'(1);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   pred_entry_t mem [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_i) wr_ptr <= wr_ptr + ONE;
         if (pop_i)  rd_ptr <= rd_ptr + ONE;
      end
   end

   // Storage needs no reset: a slot is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push_i && !clear_i) mem[wr_ptr[AW-1:0]] <= wdata_i;
   end

   assign rdata_o = mem[rd_ptr[AW-1:0]];
   assign empty_o = (wr_ptr == rd_ptr);
   assign full_o  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

endmodule

// File: rtl/branch_resolver.sv
// Retires IF-stage predictions in EX, flags mispredicts, drives flush/redirect and a
// registered predictor training write. Optional: BR_PERF_CNT_EN adds perf counters.
module branch_resolver
   import br_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int XLEN  = BR_XLEN
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall_i,
   input  logic            pred_valid_i,
   input  logic [XLEN-1:0] pred_pc_i,
   input  logic [XLEN-1:0] pred_target_i,
   input  logic            pred_taken_i,
   input  logic            res_valid_i,
   input  logic [XLEN-1:0] res_pc_i,
   input  logic            res_taken_i,
   input  logic [XLEN-1:0] res_target_i,
   input  logic            res_is_jump_i,
   output logic            flush_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic            upd_valid_o,
   output logic [XLEN-1:0] upd_pc_o,
   output logic [XLEN-1:0] upd_target_o,
   output logic            upd_taken_o,
   output logic            upd_is_br_o,
   output logic            upd_mispredict_o,
   output logic            q_empty_o,
   output logic            q_full_o,
   output logic            err_o
`ifdef BR_PERF_CNT_EN
   ,
   output logic [31:0]     perf_resolved_o,
   output logic [31:0]     perf_mispred_o
`endif
);

   pred_entry_t     head;
   pred_entry_t     wr_entry;
   logic            empty;
   logic            full;
   logic            pop;
   logic            push;
   logic            push_ok;
   logic            pc_match;
   logic            mispredict;
   logic            flush;
   logic [XLEN-1:0] exp_pc;
   upd_t            upd_q;
   logic            err_q;
   logic            unused_head_taken;

   assign exp_pc   = res_taken_i ? res_target_i : res_pc_i + XLEN'(4);
   assign pop      = res_valid_i & ~stall_i;
   assign pc_match = (head.pc == res_pc_i);

   // An empty queue means the front end never saw a branch here, i.e. it fetched PC+4.
   always_comb begin
      mispredict = 1'b0;
      if (empty)          mispredict = res_taken_i;
      else if (!pc_match) mispredict = 1'b1;
      else                mispredict = (head.target != exp_pc);
   end

   assign flush   = pop & mispredict;
   assign push    = pred_valid_i & ~stall_i & ~flush;
   assign push_ok = push & (~full | pop);

   always_comb begin
      wr_entry        = '0;
      wr_entry.pc     = pred_pc_i;
      wr_entry.target = pred_target_i;
      wr_entry.taken  = pred_taken_i;
   end

   br_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_ok),
      .pop_i   (pop & ~empty),
      .clear_i (flush),
      .wdata_i (wr_entry),
      .rdata_o (head),
      .empty_o (empty),
      .full_o  (full)
   );

   assign unused_head_taken = head.taken;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
         upd_q <= '0;
      end else begin
         if ((pop && (empty || !pc_match)) || (push && full && !pop)) err_q <= 1'b1;
         upd_q.valid <= pop;
         if (pop) begin
            upd_q.pc         <= res_pc_i;
            upd_q.target     <= res_target_i;
            upd_q.taken      <= res_taken_i;
            upd_q.is_br      <= ~res_is_jump_i;
            upd_q.mispredict <= mispredict;
         end
      end
   end

`ifdef BR_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_resolved_o <= '0;
         perf_mispred_o  <= '0;
      end else begin
         if (pop)   perf_resolved_o <= perf_resolved_o + 32'd1;
         if (flush) perf_mispred_o  <= perf_mispred_o + 32'd1;
      end
   end
`endif

   assign flush_o          = flush;
   assign redirect_pc_o    = flush ? exp_pc : '0;
   assign upd_valid_o      = upd_q.valid;
   assign upd_pc_o         = upd_q.pc;
   assign upd_target_o     = upd_q.target;
   assign upd_taken_o      = upd_q.taken;
   assign upd_is_br_o      = upd_q.is_br;
   assign upd_mispredict_o = upd_q.mispredict;
   assign q_empty_o        = empty;
   assign q_full_o         = full;
   assign err_o            = err_q;

endmodule
